rf_writeback_stage: RTL and testbench

//  Write-back end of the decode/register-file path. Captures memory-stage results and drives the

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_writeback_stage_scoreboard.sv | 92 +++++++++
 rtl/rf_writeback_stage.sv | 99 +++++++++
 tb/tb_rf_writeback_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back slice.
//   DEF_DATA_W / DEF_RADDR_W / DEF_CNT_W : default widths used by the modules
//   REG_ZERO                             : hard-wired zero register ($0)
//   wb_entry_t                           : write-back stage register contents
package rf_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RADDR_W = 5;
    localparam int DEF_CNT_W   = 2;

    localparam logic [DEF_RADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                   valid;
        logic                   regwrite;
        logic [DEF_RADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_stage_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register.
// Ports:
//   clk, rst                   clock, async active-low reset
//   id_issue/id_regwrite/...   decode-side issue request and register fields
//   dec_a, dec_a_addr          release from a retiring write
//   dec_b, dec_b_addr          release from a flushed (squashed) write
//   id_rs_busy, id_rt_busy     source register has writes in flight
//   issue_stall                destination counter is saturated
//   sb_underflow               sticky flag: a release hit a zero counter
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_issue,
    input  logic               id_regwrite,
    input  logic               id_regdst,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               dec_a,
    input  logic [RADDR_W-1:0] dec_a_addr,
    input  logic               dec_b,
    input  logic [RADDR_W-1:0] dec_b_addr,
    output logic               id_rs_busy,
    output logic               id_rt_busy,
    output logic               issue_stall,
    output logic               sb_underflow
);

    localparam int NREG = 1 << RADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt_q [NREG];
    logic [CNT_W-1:0]   cnt_d [NREG];
    logic [RADDR_W-1:0] dest;
    logic               issue_req;
    logic               dest_full;
    logic               inc;
    logic               under_hit;
    logic [CNT_W+1:0]   up;
    logic [CNT_W+1:0]   dn;

    assign dest        = id_regdst ? id_rd : id_rt;
    assign issue_req   = id_issue & id_regwrite & (dest != '0);
    assign dest_full   = (cnt_q[dest] == CNT_MAX);
    assign inc         = issue_req & ~dest_full;
    assign issue_stall = issue_req & dest_full;

    assign id_rs_busy = (id_rs != '0) && (cnt_q[id_rs] != '0);
    assign id_rt_busy = (id_rt != '0) && (cnt_q[id_rt] != '0);

    // Increment and both releases may land on the same register in one
    // cycle; the net result is clamped at zero, which flags an underflow.
    always_comb begin
        under_hit = 1'b0;
        up        = '0;
        dn        = '0;
        cnt_d[0]  = '0;
        for (int i = 1; i < NREG; i++) begin
            up = {2'b00, cnt_q[i]} + (CNT_W+2)'(inc && (dest == RADDR_W'(i)));
            dn = (CNT_W+2)'(dec_a && (dec_a_addr == RADDR_W'(i)))
               + (CNT_W+2)'(dec_b && (dec_b_addr == RADDR_W'(i)));
            if (up < dn) begin
                cnt_d[i]  = '0;
                under_hit = 1'b1;
            end else begin
                cnt_d[i] = CNT_W'(up - dn);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            sb_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (under_hit) begin
                sb_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_writeback_stage.sv
// Write-back stage: captures the memory-stage result, drives the register
// file write port, feeds a forwarding tap and tracks pending writes.
// Ports:
//   clk, rst                 clock, async active-low reset
//   id_*                     decode issue interface, busy flags, issue_stall
//   mem_*                    memory-stage result presented for capture
//   wb_stall, wb_flush       hold the stage / squash the incoming result
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   fwd_valid/addr/data      retiring result for bypass
//   sb_underflow             sticky scoreboard underflow
module rf_writeback_stage
    import rf_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_issue,
    input  logic               id_regwrite,
    input  logic               id_regdst,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    output logic               id_rs_busy,
    output logic               id_rt_busy,
    output logic               issue_stall,
    input  logic               mem_valid,
    input  logic               mem_regwrite,
    input  logic               mem_memtoreg,
    input  logic [RADDR_W-1:0] mem_wreg,
    input  logic [DATA_W-1:0]  mem_alu,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               wb_stall,
    input  logic               wb_flush,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               sb_underflow
);

    wb_entry_t s_q;
    logic      live;
    logic      flush_release;

    // A flush during a stall is ignored: the stage does not capture, so the
    // instruction at the mem input is still there next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= '0;
        end else if (!wb_stall) begin
            s_q.valid    <= mem_valid & ~wb_flush;
            s_q.regwrite <= mem_regwrite;
            s_q.addr     <= mem_wreg;
            s_q.data     <= mem_memtoreg ? mem_rdata : mem_alu;
        end
    end

    assign live = s_q.valid & s_q.regwrite & (s_q.addr != REG_ZERO);

    assign rf_we     = live & ~wb_stall;
    assign rf_waddr  = s_q.addr;
    assign rf_wdata  = s_q.data;
    assign fwd_valid = live;
    assign fwd_addr  = s_q.addr;
    assign fwd_data  = s_q.data;

    // A squashed write never reaches the register file, so its pending
    // count is released here instead.
    assign flush_release = wb_flush & ~wb_stall & mem_valid & mem_regwrite
                         & (mem_wreg != '0);

    rf_scoreboard #(
        .RADDR_W (RADDR_W),
        .CNT_W   (CNT_W)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .id_issue     (id_issue),
        .id_regwrite  (id_regwrite),
        .id_regdst    (id_regdst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .dec_a        (rf_we),
        .dec_a_addr   (s_q.addr),
        .dec_b        (flush_release),
        .dec_b_addr   (mem_wreg),
        .id_rs_busy   (id_rs_busy),
        .id_rt_busy   (id_rt_busy),
        .issue_stall  (issue_stall),
        .sb_underflow (sb_underflow)
    );

endmodule

// File: tb/tb_rf_writeback_stage.sv
module tb_rf_writeback_stage;

    logic        clk;
    logic        rst;
    logic        id_issue, id_regwrite, id_regdst;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_rs_busy, id_rt_busy, issue_stall;
    logic        mem_valid, mem_regwrite, mem_memtoreg;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_alu, mem_rdata;
    logic        wb_stall, wb_flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        sb_underflow;

    int n_cmp = 0;
    int n_err = 0;

    rf_writeback_stage dut (
        .clk(clk), .rst(rst),
        .id_issue(id_issue), .id_regwrite(id_regwrite), .id_regdst(id_regdst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_busy(id_rs_busy), .id_rt_busy(id_rt_busy), .issue_stall(issue_stall),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_wreg(mem_wreg), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .sb_underflow(sb_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        id_issue = 0; id_regwrite = 0; id_regdst = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0;
        mem_wreg = 0; mem_alu = 0; mem_rdata = 0;
        wb_stall = 0; wb_flush = 0;
    endtask

    task automatic issue_rd(input logic [4:0] r);
        id_issue = 1; id_regwrite = 1; id_regdst = 1; id_rd = r;
    endtask

    task automatic present_mem(input logic [4:0] r, input logic [31:0] alu);
        mem_valid = 1; mem_regwrite = 1; mem_memtoreg = 0; mem_wreg = r; mem_alu = alu;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %0b exp 0", rf_we); end
        n_cmp++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL reset_fwd_valid got %0b exp 0", fwd_valid); end
        n_cmp++; if ({rf_waddr, rf_wdata, fwd_addr, fwd_data} !== 74'h0) begin n_err++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", rf_waddr, rf_wdata, fwd_addr, fwd_data); end
        n_cmp++; if (sb_underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %0b exp 0", sb_underflow); end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_basic_write();
        @(negedge clk); issue_rd(5); id_rs = 5;
        @(negedge clk); id_issue = 0; present_mem(5, 32'h1234); mem_rdata = 32'h5555;
        #1;
        n_cmp++; if (id_rs_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_set got %0b exp 1", id_rs_busy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL basic_we_early got %0b exp 0", rf_we); end
        @(negedge clk); mem_valid = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_err++; $display("FAIL basic_write got we=%0b a=%0d d=%h exp 1/5/1234", rf_we, rf_waddr, rf_wdata); end
        n_cmp++; if (id_rs_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_hold got %0b exp 1", id_rs_busy); end
        @(negedge clk); #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL basic_we_one_cycle got %0b exp 0", rf_we); end
        n_cmp++; if (id_rs_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_clear got %0b exp 0", id_rs_busy); end
    endtask

    task automatic test_memtoreg();
        @(negedge clk); issue_rd(6);
        @(negedge clk); id_issue = 0; present_mem(6, 32'h1); mem_memtoreg = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk); mem_valid = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL memtoreg_data got we=%0b d=%h exp 1/deadbeef", rf_we, rf_wdata); end
        n_cmp++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd6 || fwd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL memtoreg_fwd got %0b/%0d/%h exp 1/6/deadbeef", fwd_valid, fwd_addr, fwd_data); end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        @(negedge clk); id_issue = 1; id_regwrite = 1; id_regdst = 0; id_rt = 0; id_rs = 0;
        #1;
        n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL zero_stall got %0b exp 0", issue_stall); end
        @(negedge clk); id_issue = 0; present_mem(0, 32'hFFFF);
        #1;
        n_cmp++; if (id_rt_busy !== 1'b0 || id_rs_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got %0b/%0b exp 0/0", id_rs_busy, id_rt_busy); end
        @(negedge clk); mem_valid = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin n_err++; $display("FAIL zero_we got %0b/%0b exp 0/0", rf_we, fwd_valid); end
        @(negedge clk); #1;
        n_cmp++; if (sb_underflow !== 1'b0) begin n_err++; $display("FAIL zero_underflow got %0b exp 0", sb_underflow); end
    endtask

    task automatic test_saturate_back_to_back();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); issue_rd(7);
            #1;
            n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL sat_fill%0d got %0b exp 0", i, issue_stall); end
        end
        @(negedge clk); #1;
        n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL sat_stall got %0b exp 1", issue_stall); end
        @(negedge clk); #1;
        n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL sat_hold got %0b exp 1", issue_stall); end
        id_issue = 0; present_mem(7, 32'hA1);
        @(negedge clk); mem_alu = 32'hB2; id_issue = 1;
        #1;
        n_cmp++; if (issue_stall !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'hA1) begin n_err++; $display("FAIL b2b_first got st=%0b we=%0b d=%h exp 1/1/a1", issue_stall, rf_we, rf_wdata); end
        id_issue = 0;
        @(negedge clk); mem_valid = 0; id_issue = 1;
        #1;
        n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL sat_release got %0b exp 0", issue_stall); end
        n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'hB2) begin n_err++; $display("FAIL b2b_second got we=%0b d=%h exp 1/b2", rf_we, rf_wdata); end
        id_issue = 0; id_rs = 7;
        @(negedge clk); present_mem(7, 32'hC3);
        #1;
        n_cmp++; if (id_rs_busy !== 1'b1) begin n_err++; $display("FAIL sat_one_left got %0b exp 1", id_rs_busy); end
        @(negedge clk); mem_valid = 0;
        @(negedge clk); #1;
        n_cmp++; if (id_rs_busy !== 1'b0) begin n_err++; $display("FAIL sat_drained got %0b exp 0", id_rs_busy); end
    endtask

    task automatic test_wb_stall();
        @(negedge clk); issue_rd(10); id_rs = 10;
        @(negedge clk); id_issue = 0; present_mem(10, 32'hA5A5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_valid = 0; mem_wreg = 11; mem_alu = 32'hBBBB; wb_stall = 1;
            #1;
            n_cmp++; if (rf_we !== 1'b0 || fwd_valid !== 1'b1 || rf_wdata !== 32'hA5A5 || rf_waddr !== 5'd10) begin n_err++; $display("FAIL stall_hold%0d got we=%0b fv=%0b a=%0d d=%h exp 0/1/10/a5a5", i, rf_we, fwd_valid, rf_waddr, rf_wdata); end
        end
        @(negedge clk); wb_stall = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'hA5A5 || id_rs_busy !== 1'b1) begin n_err++; $display("FAIL stall_release got we=%0b d=%h busy=%0b exp 1/a5a5/1", rf_we, rf_wdata, id_rs_busy); end
        @(negedge clk); #1;
        n_cmp++; if (rf_we !== 1'b0 || id_rs_busy !== 1'b0 || sb_underflow !== 1'b0) begin n_err++; $display("FAIL stall_single_write got we=%0b busy=%0b uf=%0b exp 0/0/0", rf_we, id_rs_busy, sb_underflow); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); issue_rd(9); id_rs = 9;
        @(negedge clk);
        @(negedge clk); id_issue = 0; present_mem(9, 32'h99);
        @(negedge clk); issue_rd(9); wb_flush = 1;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || issue_stall !== 1'b0) begin n_err++; $display("FAIL same_setup got we=%0b st=%0b exp 1/0", rf_we, issue_stall); end
        @(negedge clk); id_issue = 0; wb_flush = 0; mem_valid = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || id_rs_busy !== 1'b1) begin n_err++; $display("FAIL same_count_one got we=%0b busy=%0b exp 0/1", rf_we, id_rs_busy); end
        present_mem(9, 32'h9A);
        @(negedge clk); mem_valid = 0;
        @(negedge clk); #1;
        n_cmp++; if (id_rs_busy !== 1'b0 || sb_underflow !== 1'b0) begin n_err++; $display("FAIL same_drained got busy=%0b uf=%0b exp 0/0", id_rs_busy, sb_underflow); end
    endtask

    task automatic test_underflow();
        @(negedge clk); present_mem(12, 32'h12);
        @(negedge clk); mem_valid = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b1 || sb_underflow !== 1'b0) begin n_err++; $display("FAIL uf_pre got we=%0b uf=%0b exp 1/0", rf_we, sb_underflow); end
        @(negedge clk); #1;
        n_cmp++; if (sb_underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got %0b exp 1", sb_underflow); end
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (sb_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got %0b exp 1", sb_underflow); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); issue_rd(13); id_rs = 13;
        @(negedge clk); id_issue = 0; present_mem(13, 32'h77);
        @(negedge clk); mem_valid = 0; wb_stall = 1;
        #1;
        n_cmp++; if (fwd_valid !== 1'b1 || id_rs_busy !== 1'b1) begin n_err++; $display("FAIL ar_pre got fv=%0b busy=%0b exp 1/1", fwd_valid, id_rs_busy); end
        #1 rst = 0;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || sb_underflow !== 1'b0) begin n_err++; $display("FAIL ar_flags got we=%0b fv=%0b uf=%0b exp 0/0/0", rf_we, fwd_valid, sb_underflow); end
        n_cmp++; if ({rf_waddr, rf_wdata, fwd_addr, fwd_data} !== 74'h0 || id_rs_busy !== 1'b0) begin n_err++; $display("FAIL ar_data got %h/%h/%h/%h busy=%0b exp 0", rf_waddr, rf_wdata, fwd_addr, fwd_data, id_rs_busy); end
        @(negedge clk); idle_inputs(); rst = 1;
        @(negedge clk); #1;
        n_cmp++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin n_err++; $display("FAIL ar_after got we=%0b fv=%0b exp 0/0", rf_we, fwd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_memtoreg();
        test_zero_reg();
        test_saturate_back_to_back();
        test_wb_stall();
        test_same_cycle();
        test_underflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
